// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds/subtracts WIDTH-bit operands through one 4-bit slice,
// one nibble per clock, LSB nibble first, behind valid/ready request and response ports.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    input  logic             cin_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int IW = $clog2(NIBBLES);

    generate
        if (WIDTH % 4 != 0 || WIDTH < 8) begin : g_bad_width
            $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and at least 8");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, next;

    logic [WIDTH-1:0] a_q, b_q;
    logic             carry;
    logic [IW-1:0]    idx;
    logic [4:0]       slice;
    logic             last, accept;

    assign accept = start_valid && state == IDLE;
    assign last   = idx == IW'(NIBBLES - 1);
    // The only adder in the block: 4 + 4 + 1 -> 5 bits.
    assign slice  = {1'b0, a_q[{idx, 2'b00} +: 4]} + {1'b0, b_q[{idx, 2'b00} +: 4]} + {4'b0, carry};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start_valid ? RUN : IDLE;
            RUN:     next = last ? DONE : RUN;
            DONE:    next = res_ready ? IDLE : DONE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        start_ready = state == IDLE;
        res_valid   = state == DONE;
        busy        = state != IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_q   <= op_a;
            b_q   <= sub ? ~op_b : op_b;
            carry <= sub | cin_in;
            idx   <= '0;
        end else if (state == RUN) begin
            result[{idx, 2'b00} +: 4] <= slice[3:0];
            carry <= slice[4];
            idx   <= last ? '0 : idx + 1'b1;
            if (last) begin
                cout     <= slice[4];
                overflow <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice[3] != a_q[WIDTH-1]);
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed and randomized checks of the nibble-serial
// adder against a full-width arithmetic reference model.
module tb_nibble_serial_add_ctrl;
    localparam int W = 16;

    logic         clk = 0, rst_n = 0;
    logic         start_valid = 0, start_ready;
    logic [W-1:0] op_a = 0, op_b = 0;
    logic         sub = 0, cin_in = 0;
    logic         res_valid, res_ready = 0;
    logic [W-1:0] result;
    logic         cout, overflow, busy;

    int total = 0, bad = 0;
    time acc_time;

    nibble_serial_add_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub), .cin_in(cin_in), .res_valid(res_valid),
        .res_ready(res_ready), .result(result), .cout(cout), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference: plain W+1-bit arithmetic with signed range check for overflow.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic c, output logic [W-1:0] r, output logic co, output logic ov);
        logic [W:0] full;
        longint sa, sb, sr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (s) begin
            full = {1'b0, a} - {1'b0, b};
            co   = a >= b;
            sr   = sa - sb;
        end else begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
            co   = full[W];
            sr   = sa + sb + longint'(c);
        end
        r  = full[W-1:0];
        ov = sr > 32767 || sr < -32768;
    endtask

    // Drives one request, scrambles inputs after accept, waits for the result,
    // stalls res_ready for `stall` cycles, returns the outputs seen just before handshake.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          input logic c, input int stall, output logic [W-1:0] r,
                          output logic co, output logic ov, output int lat);
        int n;
        start_valid = 1; op_a = a; op_b = b; sub = s; cin_in = c;
        n = 0;
        while (!start_ready && n < 100) begin @(posedge clk); #1; n++; end
        @(posedge clk);
        acc_time = $time;
        #1;
        start_valid = 0;
        op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom); cin_in = 1'($urandom);
        lat = 0;
        while (!res_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        repeat (stall) begin @(posedge clk); #1; end
        r = result; co = cout; ov = overflow;
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    task automatic test_reset;
        rst_n = 0;
        #12;
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL reset_start_ready got=%b exp=1", start_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b exp=0", res_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if ({result, cout, overflow} !== '0) begin bad++; $display("FAIL reset_outputs got=%h/%b/%b exp=0/0/0", result, cout, overflow); end
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
    endtask

    task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic s, input logic c);
        logic [W-1:0] r, er;
        logic co, ov, eco, eov;
        int lat;
        model(a, b, s, c, er, eco, eov);
        run_op(a, b, s, c, 0, r, co, ov, lat);
        total++; if (lat !== 4) begin bad++; $display("FAIL %s_latency got=%0d exp=4", name, lat); end
        total++; if (r !== er) begin bad++; $display("FAIL %s_result got=%h exp=%h", name, r, er); end
        total++; if (co !== eco) begin bad++; $display("FAIL %s_cout got=%b exp=%b", name, co, eco); end
        total++; if (ov !== eov) begin bad++; $display("FAIL %s_overflow got=%b exp=%b", name, ov, eov); end
    endtask

    task automatic test_add;
        check_op("add_basic", 16'h1234, 16'h4321, 0, 0);
        check_op("add_ripple", 16'hFFFF, 16'h0001, 0, 0);
        check_op("add_ovf", 16'h7FFF, 16'h0001, 0, 0);
        check_op("add_cin", 16'h00FF, 16'h0F00, 0, 1);
    endtask

    task automatic test_sub;
        check_op("sub_neg", 16'h0005, 16'h0007, 1, 1);
        check_op("sub_ovf", 16'h8000, 16'h0001, 1, 0);
        check_op("sub_min", 16'h0000, 16'h8000, 1, 0);
    endtask

    task automatic test_backpressure;
        logic [W-1:0] hr, er, na, nb;
        logic hco, hov, eco, eov, ns, nc;
        int n;
        start_valid = 1; op_a = 16'h1234; op_b = 16'h4321; sub = 0; cin_in = 0;
        @(posedge clk); #1;
        n = 0;
        while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
        total++; if (n !== 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", n); end
        hr = result; hco = cout; hov = overflow;
        for (int i = 0; i < 10; i++) begin
            op_a = W'($urandom); op_b = W'($urandom); sub = 1'($urandom); cin_in = 1'($urandom);
            @(posedge clk); #1;
            total++;
            if ({result, cout, overflow, res_valid, start_ready} !== {hr, hco, hov, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL bp_hold cycle=%0d got=%h/%b/%b v=%b rdy=%b exp=%h/%b/%b v=1 rdy=0",
                         i, result, cout, overflow, res_valid, start_ready, hr, hco, hov);
            end
        end
        total++; if (hr !== 16'h5555) begin bad++; $display("FAIL bp_result got=%h exp=5555", hr); end
        na = op_a; nb = op_b; ns = sub; nc = cin_in;
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
        total++; if ({start_ready, res_valid} !== 2'b10) begin bad++; $display("FAIL bp_idle rdy/valid got=%b%b exp=10", start_ready, res_valid); end
        @(posedge clk); #1;
        start_valid = 0;
        total++; if ({busy, start_ready} !== 2'b10) begin bad++; $display("FAIL bp_accept busy/rdy got=%b%b exp=10", busy, start_ready); end
        n = 0;
        while (!res_valid && n < 50) begin @(posedge clk); #1; n++; end
        model(na, nb, ns, nc, er, eco, eov);
        total++; if ({result, cout, overflow} !== {er, eco, eov}) begin bad++; $display("FAIL bp_pending got=%h/%b/%b exp=%h/%b/%b", result, cout, overflow, er, eco, eov); end
        res_ready = 1;
        @(posedge clk); #1;
        res_ready = 0;
    endtask

    task automatic test_reset_mid;
        int seen;
        start_valid = 1; op_a = 16'h1234; op_b = 16'h4321; sub = 0; cin_in = 0;
        @(posedge clk); #1;
        start_valid = 0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        total++;
        if ({start_ready, res_valid, busy, result, cout, overflow} !== {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid rdy=%b v=%b busy=%b res=%h co=%b ov=%b exp 1/0/0/0000/0/0",
                     start_ready, res_valid, busy, result, cout, overflow);
        end
        @(negedge clk); rst_n = 1;
        seen = 0;
        repeat (8) begin @(posedge clk); #1; if (res_valid) seen++; end
        total++; if (seen !== 0) begin bad++; $display("FAIL reset_mid_no_valid got=%0d exp=0", seen); end
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL reset_mid_ready got=%b exp=1", start_ready); end
        check_op("after_reset", 16'h0001, 16'h0001, 0, 0);
    endtask

    task automatic test_throughput;
        logic [W-1:0] r;
        logic co, ov;
        int lat;
        time t0;
        run_op(16'h1111, 16'h2222, 0, 0, 0, r, co, ov, lat);
        t0 = acc_time;
        run_op(16'h3333, 16'h0101, 1, 0, 0, r, co, ov, lat);
        total++; if (acc_time - t0 !== 60) begin bad++; $display("FAIL throughput got=%0t exp=60", acc_time - t0); end
        total++; if (r !== 16'h3232) begin bad++; $display("FAIL throughput_result got=%h exp=3232", r); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] a, b, r, er;
        logic s, c, co, ov, eco, eov;
        int lat, errs;
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            a = W'($urandom); b = W'($urandom); s = 1'($urandom); c = 1'($urandom);
            if (i % 7 == 0) a = W'($urandom_range(0, 1)) ? 16'hFFFF : 16'h8000;
            model(a, b, s, c, er, eco, eov);
            run_op(a, b, s, c, int'($urandom_range(0, 3)), r, co, ov, lat);
            if (lat !== 4 || r !== er || co !== eco || ov !== eov) begin
                errs++;
                if (errs <= 5)
                    $display("FAIL random op=%0d a=%h b=%h sub=%b cin=%b got=%h/%b/%b lat=%0d exp=%h/%b/%b lat=4",
                             i, a, b, s, c, r, co, ov, lat, er, eco, eov);
            end
        end
        total++; if (errs !== 0) begin bad++; $display("FAIL random_total got=%0d errors exp=0", errs); end
    endtask

    initial begin
        test_reset;
        test_add;
        test_sub;
        test_backpressure;
        test_reset_mid;
        test_throughput;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
